// File: rtl/open_collector_bus_driver_if.sv
// rtl/open_collector_bus_driver_if.sv - control/status bundle between control logic and the open-collector driver
interface open_collector_bus_driver_if #(
    parameter int CHANNELS = 8
);
    logic                oe;
    logic [CHANNELS-1:0] din;
    logic                clr_fault;
    logic [CHANNELS-1:0] rdata;
    logic [CHANNELS-1:0] contend;
    logic [CHANNELS-1:0] fault;

    modport master (
        output oe, din, clr_fault,
        input  rdata, contend, fault
    );

    modport slave (
        input  oe, din, clr_fault,
        output rdata, contend, fault
    );
endinterface

// File: rtl/open_collector_bus_driver.sv
// rtl/open_collector_bus_driver.sv - multi-channel open-collector driver with filtered readback; OC_FAULT_CHECK_EN enables stuck-high fault flags
module open_collector_bus_driver #(
    parameter int CHANNELS      = 8,
    parameter int FILTER_CYCLES = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    open_collector_bus_driver_if.slave   bus,
    inout  wire  [CHANNELS-1:0]          dout_io
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_DRIVING,
        ST_SETTLING
    } state_e;

    logic [CHANNELS-1:0] drive_q;
    logic [CHANNELS-1:0] drive_d;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    assign drive_d = bus.din & {CHANNELS{bus.oe}};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drive_q <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            drive_q <= drive_d;
            sync1_q <= dout_io;
            sync2_q <= sync1_q;
        end
    end

`ifndef OC_FAULT_CHECK_EN
    logic unused_clr_fault;
    assign unused_clr_fault = bus.clr_fault;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_e        state_q;
        logic [TW-1:0] timer_q;
        logic [FW-1:0] filt_q;
        logic          rdata_q;
        logic          contend_q;

        // Never drive a 1: the external pull-up supplies the high level.
        assign dout_io[g]     = drive_q[g] ? 1'b0 : 1'bz;
        assign bus.rdata[g]   = rdata_q;
        assign bus.contend[g] = contend_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q   <= ST_RELEASED;
                timer_q   <= '0;
                filt_q    <= '0;
                rdata_q   <= 1'b1;
                contend_q <= 1'b0;
            end else begin
                if (sync2_q[g] == rdata_q) begin
                    filt_q <= '0;
                end else if (filt_q == FW'(FILTER_CYCLES - 1)) begin
                    rdata_q <= sync2_q[g];
                    filt_q  <= '0;
                end else begin
                    filt_q <= filt_q + FW'(1);
                end

                // Low seen while settling is our own tail, not another agent.
                contend_q <= (state_q == ST_RELEASED) && !rdata_q;

                case (state_q)
                    ST_RELEASED: begin
                        if (drive_q[g]) begin
                            state_q <= ST_DRIVING;
                            timer_q <= TW'(SETTLE_CYCLES);
                        end
                    end
                    ST_DRIVING: begin
                        if (!drive_q[g]) begin
                            state_q <= ST_SETTLING;
                            timer_q <= TW'(SETTLE_CYCLES);
                        end else if (timer_q != '0) begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    ST_SETTLING: begin
                        if (drive_q[g]) begin
                            state_q <= ST_DRIVING;
                            timer_q <= TW'(SETTLE_CYCLES);
                        end else if (timer_q == '0) begin
                            state_q <= ST_RELEASED;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_RELEASED;
                        timer_q <= '0;
                    end
                endcase
            end
        end

`ifdef OC_FAULT_CHECK_EN
        logic fault_q;

        assign bus.fault[g] = fault_q;

        // Set has priority so a fault still present is never lost to a clear.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                fault_q <= 1'b0;
            end else if (state_q == ST_DRIVING && timer_q == '0 && rdata_q) begin
                fault_q <= 1'b1;
            end else if (bus.clr_fault) begin
                fault_q <= 1'b0;
            end
        end
`else
        assign bus.fault[g] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_open_collector_bus_driver.sv
// tb/tb_open_collector_bus_driver.sv - self-checking bench with history-based reference model
module tb_open_collector_bus_driver;
    localparam int CH = 4;
    localparam int F  = 3;
    localparam int S  = 4;

    logic clk;
    logic rst_n;
    logic [CH-1:0] ext_low;
    logic [CH-1:0] ext_hi;
    wire  [CH-1:0] dout;

    int checks   = 0;
    int failures = 0;

    open_collector_bus_driver_if #(.CHANNELS(CH)) bus ();

    open_collector_bus_driver #(
        .CHANNELS(CH),
        .FILTER_CYCLES(F),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(bus),
        .dout_io(dout)
    );

    for (genvar g = 0; g < CH; g++) begin : g_line
        pullup (dout[g]);
        assign dout[g] = ext_hi[g] ? 1'b1 : (ext_low[g] ? 1'b0 : 1'bz);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: pin_h[c][0] is the line sampled at the latest edge,
    // d_h[c][0] is the commanded drive after the latest edge.
    logic [7:0]    pin_h [CH];
    logic [7:0]    d_h   [CH];
    logic [CH-1:0] m_rd;
    logic [CH-1:0] m_ct;
    logic [CH-1:0] m_ft;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            pin_h[c] = 8'hFF;
            d_h[c]   = 8'h00;
        end
        m_rd = '1;
        m_ct = '0;
        m_ft = '0;
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < CH; c++) begin
            logic pin_pre, all_diff, drv_run, released, rd_pre;
            pin_pre  = ext_hi[c] ? 1'b1 : ((d_h[c][0] | ext_low[c]) ? 1'b0 : 1'b1);
            pin_h[c] = {pin_h[c][6:0], pin_pre};
            rd_pre   = m_rd[c];
            // the filter sees the line two edges late and needs F opposite samples in a row
            all_diff = 1'b1;
            for (int j = 2; j <= F + 1; j++)
                if (pin_h[c][j] == rd_pre) all_diff = 1'b0;
            drv_run  = &d_h[c][S+1:1];
            released = ~|d_h[c][S+2:1];
            m_ct[c]  = released & ~rd_pre;
`ifdef OC_FAULT_CHECK_EN
            m_ft[c]  = (drv_run & rd_pre) | (m_ft[c] & ~bus.clr_fault);
`else
            m_ft[c]  = 1'b0;
            if (drv_run) m_ft[c] = 1'b0;
`endif
            if (all_diff) m_rd[c] = ~rd_pre;
            d_h[c] = {d_h[c][6:0], bus.din[c] & bus.oe};
        end
    endfunction

    function automatic logic [CH-1:0] exp_pins();
        logic [CH-1:0] p;
        for (int c = 0; c < CH; c++)
            p[c] = ext_hi[c] ? 1'b1 : ((d_h[c][0] | ext_low[c]) ? 1'b0 : 1'b1);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("dout",    dout,        exp_pins());
        chk("rdata",   bus.rdata,   m_rd);
        chk("contend", bus.contend, m_ct);
        chk("fault",   bus.fault,   m_ft);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            model_edge();
            compare_all();
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.oe        = 1'b0;
        bus.din       = '0;
        bus.clr_fault = 1'b0;
        ext_low       = '0;
        ext_hi        = '0;
        model_reset();

        // 1: asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("t1_dout",    dout,        4'b1111);
        chk("t1_rdata",   bus.rdata,   4'b1111);
        chk("t1_contend", bus.contend, 4'b0000);
        chk("t1_fault",   bus.fault,   4'b0000);
        #10 rst_n = 1'b1;
        tick(3);

        // 2: drive channel 0, readback latency
        bus.oe  = 1'b1;
        bus.din = 4'b0001;
        tick();
        chk("t2_dout_low", dout, 4'b1110);
        tick(4);
        chk("t2_rdata_n4", bus.rdata, 4'b1111);
        tick();
        chk("t2_rdata_n5", bus.rdata, 4'b1110);
        tick(5);
        chk("t2_no_fault", bus.fault, 4'b0000);
        bus.din = 4'b0000;
        tick();
        chk("t2_dout_rel", dout, 4'b1111);
        tick(4);
        chk("t2_rel_n4", bus.rdata, 4'b1110);
        tick();
        chk("t2_rel_n5", bus.rdata, 4'b1111);
        tick(8);

        // 3: external pulls on channel 1
        ext_low[1] = 1'b1;
        tick(2);
        ext_low[1] = 1'b0;
        tick(6);
        chk("t3_glitch_rdata",   bus.rdata,   4'b1111);
        chk("t3_glitch_contend", bus.contend, 4'b0000);
        ext_low[1] = 1'b1;
        tick(6);
        chk("t3_pull_rdata",   bus.rdata,   4'b1101);
        chk("t3_pull_contend", bus.contend, 4'b0010);
        ext_low[1] = 1'b0;
        tick(8);
        chk("t3_rel_rdata",   bus.rdata,   4'b1111);
        chk("t3_rel_contend", bus.contend, 4'b0000);

        // 4: stuck-high on channel 2
        ext_hi[2] = 1'b1;
        bus.din   = 4'b0100;
        tick(6);
        chk("t4_fault_early", bus.fault, 4'b0000);
        tick();
`ifdef OC_FAULT_CHECK_EN
        chk("t4_fault_set", bus.fault, 4'b0100);
`else
        chk("t4_fault_off", bus.fault, 4'b0000);
`endif
        bus.clr_fault = 1'b1;
        tick();
        bus.clr_fault = 1'b0;
`ifdef OC_FAULT_CHECK_EN
        chk("t4_fault_held", bus.fault, 4'b0100);
`else
        chk("t4_fault_held_off", bus.fault, 4'b0000);
`endif
        ext_hi[2] = 1'b0;
        tick(10);
        bus.clr_fault = 1'b1;
        tick();
        bus.clr_fault = 1'b0;
        chk("t4_fault_clr", bus.fault, 4'b0000);
        bus.din = 4'b0000;
        tick(10);

        // 5: output enable dropped mid-drive
        bus.din = 4'b1111;
        tick(10);
        bus.oe = 1'b0;
        tick();
        chk("t5_dout", dout, 4'b1111);
        tick(10);
        chk("t5_rdata",   bus.rdata,   4'b1111);
        chk("t5_contend", bus.contend, 4'b0000);
        chk("t5_fault",   bus.fault,   4'b0000);

        // 6: asynchronous reset mid-drive
        bus.oe = 1'b1;
        tick(10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_dout",  dout,      4'b1111);
        chk("t6_rdata", bus.rdata, 4'b1111);
        chk("t6_fault", bus.fault, 4'b0000);
        #2 rst_n = 1'b1;
        bus.din = 4'b0000;
        tick(10);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0)  bus.din[c] = ~bus.din[c];
                if ($urandom_range(0, 11) == 0) ext_low[c] = ~ext_low[c];
                if (ext_hi[c]) begin
                    if ($urandom_range(0, 5) == 0) ext_hi[c] = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    ext_hi[c] = 1'b1;
                end
            end
            bus.oe        = ($urandom_range(0, 31) != 0);
            bus.clr_fault = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
